// File: rtl/uriscv_muldiv_radix_if.sv
// Request/response bundle between the uRISC-V execute stage and the
// multiply/divide unit.
//   master : execute stage; drives the op request, operands and flush,
//            receives stall, ready and result.
//   slave  : muldiv unit; the opposite directions.
// XLEN must match the XLEN of the unit it is connected to.
interface uriscv_muldiv_radix_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            inst_mul_i;
    logic            inst_mulh_i;
    logic            inst_mulhsu_i;
    logic            inst_mulhu_i;
    logic            inst_div_i;
    logic            inst_divu_i;
    logic            inst_rem_i;
    logic            inst_remu_i;
    logic [XLEN-1:0] operand_ra_i;
    logic [XLEN-1:0] operand_rb_i;
    logic            flush_i;
    logic            stall_o;
    logic            ready_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i,
               inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i,
               operand_ra_i, operand_rb_i, flush_i,
        input  stall_o, ready_o, result_o
    );

    modport slave (
        input  valid_i, inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i,
               inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i,
               operand_ra_i, operand_rb_i, flush_i,
        output stall_o, ready_o, result_o
    );
endinterface

// File: rtl/uriscv_muldiv_radix.sv
// RV32M/RV64M multiply/divide unit for the uRISC-V execute stage.
//   - Multiplier: operand capture register, MUL_STAGES-deep valid pipe,
//     one op accepted per cycle, results retire in order.
//   - Divider: iterative unsigned restoring divider on operand magnitudes,
//     DIV_BITS quotient bits per cycle, divide-by-zero early-out, sign fix-up
//     in a final cycle.
//   - flush_i kills everything accepted but not yet shown on ready_o.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous reset, active high
//   bus    slave side of uriscv_muldiv_radix_if (request, operands, flush,
//          stall, ready pulse, registered result)
module uriscv_muldiv_radix #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 1,
    parameter int DIV_BITS   = 1
) (
    input logic                  clk_i,
    input logic                  rst_i,
    uriscv_muldiv_radix_if.slave bus
);
    localparam int ITERS = XLEN / DIV_BITS;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int PW    = 2 * XLEN + 2;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} div_state_e;

    // ------------------------------------------------------------------
    // Decode and issue control
    // ------------------------------------------------------------------
    logic is_mul_op, is_div_op, mul_busy, div_busy, stall;
    logic mul_acc, div_acc;
    logic [MUL_STAGES-1:0] vld_pipe;
    div_state_e state_q, state_d;

    assign is_mul_op = bus.inst_mul_i | bus.inst_mulh_i | bus.inst_mulhsu_i | bus.inst_mulhu_i;
    assign is_div_op = bus.inst_div_i | bus.inst_divu_i | bus.inst_rem_i | bus.inst_remu_i;
    assign mul_busy  = |vld_pipe;
    assign div_busy  = (state_q != S_IDLE);

    // A mul can never overtake a running divide and a divide never starts
    // while muls are in flight, so only one source reaches ready_o per cycle.
    assign stall       = (div_busy & (is_mul_op | is_div_op)) | (mul_busy & is_div_op);
    assign bus.stall_o = stall;

    assign mul_acc = bus.valid_i & is_mul_op & ~stall & ~bus.flush_i;
    assign div_acc = bus.valid_i & is_div_op & ~stall & ~bus.flush_i;

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    logic signed [XLEN:0]   ma_q, mb_q;
    logic                   mhi_q;
    logic signed [PW-1:0]   mprod;
    logic [XLEN-1:0]        mul_sel, mul_out;
    logic                   mul_done;
    logic                   unused_mprod;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ma_q  <= '0;
            mb_q  <= '0;
            mhi_q <= 1'b0;
        end else if (mul_acc) begin
            // XLEN+1-bit operands cover signed and unsigned in one signed multiply
            ma_q  <= {(bus.inst_mulh_i | bus.inst_mulhsu_i) & bus.operand_ra_i[XLEN-1],
                      bus.operand_ra_i};
            mb_q  <= {bus.inst_mulh_i & bus.operand_rb_i[XLEN-1], bus.operand_rb_i};
            mhi_q <= ~bus.inst_mul_i;
        end
    end

    assign mprod        = PW'(ma_q) * PW'(mb_q);
    assign mul_sel      = mhi_q ? mprod[2*XLEN-1:XLEN] : mprod[XLEN-1:0];
    assign unused_mprod = ^mprod[PW-1:2*XLEN];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
        end else if (bus.flush_i) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= mul_acc;
            for (int k = 1; k < MUL_STAGES; k++)
                vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    // Stage 0 holds operands; each further stage holds the selected product.
    generate
        if (MUL_STAGES == 1) begin : g_mul_s1
            assign mul_out = mul_sel;
        end else begin : g_mul_sn
            logic [MUL_STAGES-1:1][XLEN-1:0] mres_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    mres_q <= '0;
                end else begin
                    mres_q[1] <= mul_sel;
                    for (int k = 2; k < MUL_STAGES; k++)
                        mres_q[k] <= mres_q[k-1];
                end
            end
            assign mul_out = mres_q[MUL_STAGES-1];
        end
    endgenerate

    assign mul_done = vld_pipe[MUL_STAGES-1];

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q, want_rem_q;
    logic            div_done;
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN:0]   part;
    logic            step_ge;
    logic            sgn, ra_neg, rb_neg, rb_zero;
    logic [XLEN-1:0] a_mag, b_mag, div_res;

    assign sgn     = bus.inst_div_i | bus.inst_rem_i;
    assign ra_neg  = sgn & bus.operand_ra_i[XLEN-1];
    assign rb_neg  = sgn & bus.operand_rb_i[XLEN-1];
    assign rb_zero = (bus.operand_rb_i == '0);
    assign a_mag   = ra_neg ? -bus.operand_ra_i : bus.operand_ra_i;
    assign b_mag   = rb_neg ? -bus.operand_rb_i : bus.operand_rb_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        div_done = 1'b0;
        unique case (state_q)
            S_IDLE: if (div_acc) state_d = rb_zero ? S_FIN : S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIN;
            S_FIN: begin
                div_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush_i) state_d = S_IDLE;
    end

    // DIV_BITS restoring steps: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits, record the quotient bit.
    always_comb begin
        step_rem = rem_q;
        step_quo = quo_q;
        part     = '0;
        step_ge  = 1'b0;
        for (int i = 0; i < DIV_BITS; i++) begin
            part    = {step_rem, step_quo[XLEN-1]};
            step_ge = (part >= {1'b0, dvs_q});
            if (step_ge) part = part - {1'b0, dvs_q};
            step_rem = part[XLEN-1:0];
            step_quo = {step_quo[XLEN-2:0], step_ge};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            want_rem_q <= 1'b0;
        end else if (div_acc) begin
            dvs_q      <= b_mag;
            cnt_q      <= CW'(ITERS - 1);
            want_rem_q <= bus.inst_rem_i | bus.inst_remu_i;
            neg_q      <= bus.inst_rem_i ? ra_neg
                                         : ((ra_neg ^ rb_neg) & ~rb_zero);
            if (rb_zero) begin
                // Early-out: remainder magnitude re-signed in S_FIN gives ra back
                quo_q <= '1;
                rem_q <= a_mag;
            end else begin
                quo_q <= a_mag;
                rem_q <= '0;
            end
        end else if (state_q == S_CALC) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_comb begin
        div_res = want_rem_q ? rem_q : quo_q;
        if (neg_q) div_res = -div_res;
    end

    // ------------------------------------------------------------------
    // Result register; a flush kills whatever would land at this edge.
    // ------------------------------------------------------------------
    logic            ready_q;
    logic [XLEN-1:0] result_q;
    logic            retire;

    assign retire = (mul_done | div_done) & ~bus.flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            ready_q <= retire;
            if (retire) result_q <= mul_done ? mul_out : div_res;
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.result_o = result_q;
endmodule
